// File: rtl/binary_rank_filter.sv
// K x K rank filter on a binary mask (pixel_in[0]). It supports median, erode, dilate and custom rank.
// Sync bits leave from the centre tap, so they stay aligned with the filtered pixel.
module binary_rank_filter #(
   parameter int H_SIZE = 1664,
   parameter int K      = 5,
   parameter int CW     = $clog2(K*K+1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          de_in,
   input  logic          h_sync_in,
   input  logic          v_sync_in,
   input  logic [23:0]   pixel_in,
   input  logic [1:0]    mode,
   input  logic [CW-1:0] rank,
   output logic          de_out,
   output logic          h_sync_out,
   output logic          v_sync_out,
   output logic [23:0]   pixel_out
);

   localparam int C        = (K-1)/2;
   localparam int AW       = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
   localparam int FILL_MAX = (K-1)*H_SIZE + (K-1);
   localparam int FW       = $clog2(FILL_MAX+1);
   localparam int RW       = $clog2(K+1);

   // Bundle layout: {mask, de, h_sync, v_sync}
   logic [3:0]    row_in [K];
   logic [3:0]    win    [K][K];

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr;
   logic [FW-1:0] fill_cnt_reg;
   logic          fill_done;

   logic          vs_prev_reg;
   logic [1:0]    mode_reg;
   logic [CW-1:0] rank_reg;
   logic [CW-1:0] thr;

   logic [RW-1:0] row_cnt_next [K];
   logic [RW-1:0] row_cnt_reg  [K];
   logic          ctx_next;
   logic          ctx1_reg;
   logic [2:0]    sync1_reg;
   logic [CW-1:0] sum_next;
   logic [CW-1:0] cnt2_reg;
   logic          ctx2_reg;
   logic [2:0]    sync2_reg;
   logic          pix3_reg;
   logic [2:0]    sync3_reg;

   logic          unused_pixel;
   logic          unused_sync_bits;

   assign row_in[0]    = {pixel_in[0], de_in, h_sync_in, v_sync_in};
   assign unused_pixel = ^pixel_in[23:1];

   // Read one slot ahead of the write so the RAM's registered read gives exactly H_SIZE clocks of delay.
   always_comb begin
      rd_ptr = (wr_ptr_reg == AW'(H_SIZE-1)) ? '0 : wr_ptr_reg + AW'(1);
   end

   assign fill_done = (fill_cnt_reg == FW'(FILL_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         fill_cnt_reg <= '0;
         vs_prev_reg  <= 1'b0;
         mode_reg     <= 2'd0;
         rank_reg     <= '0;
      end else begin
         wr_ptr_reg  <= rd_ptr;
         vs_prev_reg <= v_sync_in;
         if (!fill_done)
            fill_cnt_reg <= fill_cnt_reg + FW'(1);
         if (v_sync_in && !vs_prev_reg) begin
            mode_reg <= mode;
            rank_reg <= rank;
         end
      end
   end

   genvar gi, gj;

   // The line-buffer RAM is deliberately not reset. The fill guard keeps stale contents away from the outputs.
   generate
      for (gi = 0; gi < K-1; gi++) begin : g_lb
         logic [3:0] mem [H_SIZE];
         logic [3:0] q_reg;
         always_ff @(posedge clk) begin
            mem[wr_ptr_reg] <= row_in[gi];
            q_reg           <= mem[rd_ptr];
         end
         assign row_in[gi+1] = q_reg;
      end

      for (gi = 0; gi < K; gi++) begin : g_row
         logic [3:0] sr_reg [K-1];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int j = 0; j < K-1; j++)
                  sr_reg[j] <= '0;
            end else begin
               sr_reg[0] <= row_in[gi];
               for (int j = 1; j < K-1; j++)
                  sr_reg[j] <= sr_reg[j-1];
            end
         end
         assign win[gi][0] = row_in[gi];
         for (gj = 1; gj < K; gj++) begin : g_col
            assign win[gi][gj] = sr_reg[gj-1];
         end
      end
   endgenerate

   always_comb begin
      ctx_next         = fill_done;
      unused_sync_bits = 1'b0;
      for (int r = 0; r < K; r++) begin
         row_cnt_next[r] = '0;
         for (int c = 0; c < K; c++) begin
            row_cnt_next[r]  = row_cnt_next[r] + RW'(win[r][c][3]);
            ctx_next         = ctx_next & win[r][c][2];
            unused_sync_bits = unused_sync_bits ^ win[r][c][1] ^ win[r][c][0];
         end
      end
   end

   always_comb begin
      sum_next = '0;
      for (int r = 0; r < K; r++)
         sum_next = sum_next + CW'(row_cnt_reg[r]);
   end

   // A custom rank above K*K can never be met, so the output stays black. A rank of 0 always passes.
   always_comb begin
      thr = rank_reg;
      case (mode_reg)
         2'd0:    thr = CW'((K*K+1)/2);
         2'd1:    thr = CW'(K*K);
         2'd2:    thr = CW'(1);
         default: thr = rank_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++)
            row_cnt_reg[r] <= '0;
         ctx1_reg  <= 1'b0;
         sync1_reg <= '0;
         cnt2_reg  <= '0;
         ctx2_reg  <= 1'b0;
         sync2_reg <= '0;
         pix3_reg  <= 1'b0;
         sync3_reg <= '0;
      end else begin
         for (int r = 0; r < K; r++)
            row_cnt_reg[r] <= row_cnt_next[r];
         ctx1_reg  <= ctx_next;
         sync1_reg <= win[C][C][2:0];
         cnt2_reg  <= ctx1_reg ? sum_next : '0;
         ctx2_reg  <= ctx1_reg;
         sync2_reg <= sync1_reg;
         pix3_reg  <= ctx2_reg && (cnt2_reg >= thr);
         sync3_reg <= sync2_reg;
      end
   end

   assign de_out     = sync3_reg[2] & fill_done;
   assign h_sync_out = sync3_reg[1] & fill_done;
   assign v_sync_out = sync3_reg[0] & fill_done;
   assign pixel_out  = {24{pix3_reg & fill_done}};

endmodule
